vram_arbiter: RTL

//  Shares the single-port tile/video RAM between the VGA pixel-fetch path (read-only, hard priority)
//  and the game-logic port (read/write, valid/ack handshake). Sits between the VGA timing/pixel

---
 rtl/vram_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port tile/video RAM between the VGA pixel-fetch
// path and the game-logic port.
//
// The VGA path has hard priority and is never stalled. The game port uses a
// req/ack handshake and is only granted when VGA is idle. All RAM control
// outputs are registered. Read data returns to its owner at a fixed latency of
// three edges, counting the grant edge.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   vga_req_i, vga_addr_i     VGA read request/address, sampled every edge
//   vga_rvalid_o, vga_rdata_o VGA read data (rdata holds between pulses)
//   game_req_i .. _wdata_i    game request, held until game_ack_o
//   game_ack_o                one-cycle pulse at the grant edge
//   game_rvalid_o, _rdata_o   game read data (reads only)
//   game_starved_o            game_wait_cnt_o >= STARVE_MAX
//   game_wait_cnt_o           cycles the current game request has waited
//   ram_*_o                   registered RAM controls
//   ram_rdata_i               RAM read data, valid one edge after a read
module vram_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned STARVE_MAX = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vga_req_i,
    input  logic [ADDR_W-1:0] vga_addr_i,
    output logic              vga_rvalid_o,
    output logic [DATA_W-1:0] vga_rdata_o,
    input  logic              game_req_i,
    input  logic              game_we_i,
    input  logic [ADDR_W-1:0] game_addr_i,
    input  logic [DATA_W-1:0] game_wdata_i,
    output logic              game_ack_o,
    output logic              game_rvalid_o,
    output logic [DATA_W-1:0] game_rdata_o,
    output logic              game_starved_o,
    output logic [CNT_W-1:0]  game_wait_cnt_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    // A threshold wider than the counter is truncated to the counter width.
    localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CntMax    = '1;

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e state_q, state_d;

    // Slot decode
    logic              vga_slot;
    logic              game_grant;
    logic              slot_en;
    logic              slot_we;
    logic              slot_rd;
    logic [ADDR_W-1:0] slot_addr;

    // Registered state
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              tag1_valid_q, tag1_valid_d;
    logic              tag1_game_q, tag1_game_d;
    logic              tag2_valid_q, tag2_valid_d;
    logic              tag2_game_q, tag2_game_d;
    logic              vga_rvalid_q, vga_rvalid_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic              game_rvalid_q, game_rvalid_d;
    logic [DATA_W-1:0] game_rdata_q, game_rdata_d;
    logic              game_ack_q, game_ack_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin : state_reg
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. HOLD lasts exactly one edge so a master that drops
    // req on seeing ack is not granted a second time.
    // ------------------------------------------------------------------
    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (game_grant) state_d = StHold;
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (slot decode). VGA always wins the slot.
    // ------------------------------------------------------------------
    always_comb begin : slot_decode
        vga_slot   = vga_req_i;
        game_grant = !vga_req_i && game_req_i && (state_q == StIdle);
        slot_en    = vga_slot || game_grant;
        slot_we    = game_grant && game_we_i;
        slot_rd    = vga_slot || (game_grant && !game_we_i);
        slot_addr  = vga_slot ? vga_addr_i : game_addr_i;
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin : datapath_next
        ram_en_d    = slot_en;
        ram_we_d    = slot_we;
        ram_addr_d  = slot_en ? slot_addr : ram_addr_q;
        ram_wdata_d = slot_en ? game_wdata_i : ram_wdata_q;

        // Tag pipeline: stage 1 follows the RAM command, stage 2 lines up with
        // the edge at which the RAM has produced the read data.
        tag1_valid_d = slot_rd;
        tag1_game_d  = game_grant;
        tag2_valid_d = tag1_valid_q;
        tag2_game_d  = tag1_game_q;

        vga_rvalid_d  = tag2_valid_q && !tag2_game_q;
        game_rvalid_d = tag2_valid_q && tag2_game_q;
        vga_rdata_d   = vga_rvalid_d ? ram_rdata_i : vga_rdata_q;
        game_rdata_d  = game_rvalid_d ? ram_rdata_i : game_rdata_q;

        game_ack_d = game_grant;

        if (!game_req_i || game_grant) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CntMax) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    always_ff @(posedge clk_i) begin : datapath_reg
        if (rst_i) begin
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            tag1_valid_q  <= 1'b0;
            tag1_game_q   <= 1'b0;
            tag2_valid_q  <= 1'b0;
            tag2_game_q   <= 1'b0;
            vga_rvalid_q  <= 1'b0;
            vga_rdata_q   <= '0;
            game_rvalid_q <= 1'b0;
            game_rdata_q  <= '0;
            game_ack_q    <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            tag1_valid_q  <= tag1_valid_d;
            tag1_game_q   <= tag1_game_d;
            tag2_valid_q  <= tag2_valid_d;
            tag2_game_q   <= tag2_game_d;
            vga_rvalid_q  <= vga_rvalid_d;
            vga_rdata_q   <= vga_rdata_d;
            game_rvalid_q <= game_rvalid_d;
            game_rdata_q  <= game_rdata_d;
            game_ack_q    <= game_ack_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign ram_en_o        = ram_en_q;
    assign ram_we_o        = ram_we_q;
    assign ram_addr_o      = ram_addr_q;
    assign ram_wdata_o     = ram_wdata_q;
    assign vga_rvalid_o    = vga_rvalid_q;
    assign vga_rdata_o     = vga_rdata_q;
    assign game_rvalid_o   = game_rvalid_q;
    assign game_rdata_o    = game_rdata_q;
    assign game_ack_o      = game_ack_q;
    assign game_wait_cnt_o = wait_cnt_q;
    assign game_starved_o  = (wait_cnt_q >= StarveMax);

endmodule
